// File: rtl/l1_wb_arb_pkg.sv
// l1_wb_arb_pkg: shared types and constants for the L1 trigger Wishbone arbiter
package l1_wb_arb_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic GRANT_A = 1'b0;
    localparam logic GRANT_B = 1'b1;
    localparam int ERR_COUNT_BITS = 8;

    function automatic logic [ERR_COUNT_BITS-1:0] sat_inc(input logic [ERR_COUNT_BITS-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/l1_wb_arbiter.sv
// l1_wb_arbiter: two-host round-robin Wishbone arbiter with bus timeout and saturating error count
module l1_wb_arbiter
    import l1_wb_arb_pkg::*;
#(
    parameter int ADR_BITS = 15,
    parameter int DAT_BITS = 32,
    parameter int TIMEOUT  = 255
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_i,
    input  logic                      a_cyc_i,
    input  logic                      a_stb_i,
    input  logic                      a_we_i,
    input  logic [ADR_BITS-1:0]       a_adr_i,
    input  logic [DAT_BITS-1:0]       a_dat_i,
    input  logic [3:0]                a_sel_i,
    output logic                      a_ack_o,
    output logic                      a_err_o,
    output logic                      a_rty_o,
    output logic [DAT_BITS-1:0]       a_dat_o,
    input  logic                      b_cyc_i,
    input  logic                      b_stb_i,
    input  logic                      b_we_i,
    input  logic [ADR_BITS-1:0]       b_adr_i,
    input  logic [DAT_BITS-1:0]       b_dat_i,
    input  logic [3:0]                b_sel_i,
    output logic                      b_ack_o,
    output logic                      b_err_o,
    output logic                      b_rty_o,
    output logic [DAT_BITS-1:0]       b_dat_o,
    output logic                      m_cyc_o,
    output logic                      m_stb_o,
    output logic                      m_we_o,
    output logic [ADR_BITS-1:0]       m_adr_o,
    output logic [DAT_BITS-1:0]       m_dat_o,
    output logic [3:0]                m_sel_o,
    input  logic                      m_ack_i,
    input  logic                      m_err_i,
    input  logic                      m_rty_i,
    input  logic [DAT_BITS-1:0]       m_dat_i,
    output logic [ERR_COUNT_BITS-1:0] err_count_o
);

    localparam logic [7:0] TMO = 8'(TIMEOUT);

    state_t                    r_state;
    logic                      r_grant;
    logic                      r_last;
    logic [7:0]                r_timer;
    logic [ERR_COUNT_BITS-1:0] r_err_cnt;
    logic                      r_m_cyc;
    logic                      r_m_we;
    logic [ADR_BITS-1:0]       r_m_adr;
    logic [DAT_BITS-1:0]       r_m_dat;
    logic                      r_a_ack;
    logic                      r_a_err;
    logic [DAT_BITS-1:0]       r_a_dat;
    logic                      r_b_ack;
    logic                      r_b_err;
    logic [DAT_BITS-1:0]       r_b_dat;

    logic w_req_a;
    logic w_req_b;
    logic w_win;
    logic w_unused;

    assign w_req_a  = a_cyc_i & a_stb_i;
    assign w_req_b  = b_cyc_i & b_stb_i;
    // on a tie the host opposite the previous winner goes first
    assign w_win    = (w_req_a & w_req_b) ? ~r_last : (w_req_b ? GRANT_B : GRANT_A);
    assign w_unused = ^{a_sel_i, b_sel_i, m_rty_i};

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state   <= IDLE;
            r_grant   <= GRANT_A;
            r_last    <= GRANT_B;
            r_timer   <= '0;
            r_err_cnt <= '0;
            r_m_cyc   <= 1'b0;
            r_m_we    <= 1'b0;
            r_m_adr   <= '0;
            r_m_dat   <= '0;
            r_a_ack   <= 1'b0;
            r_a_err   <= 1'b0;
            r_a_dat   <= '0;
            r_b_ack   <= 1'b0;
            r_b_err   <= 1'b0;
            r_b_dat   <= '0;
        end else begin
            r_a_ack <= 1'b0;
            r_a_err <= 1'b0;
            r_b_ack <= 1'b0;
            r_b_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_req_a || w_req_b) begin
                        r_grant <= w_win;
                        r_last  <= w_win;
                        r_m_we  <= (w_win == GRANT_B) ? b_we_i  : a_we_i;
                        r_m_adr <= (w_win == GRANT_B) ? b_adr_i : a_adr_i;
                        r_m_dat <= (w_win == GRANT_B) ? b_dat_i : a_dat_i;
                        r_m_cyc <= 1'b1;
                        r_timer <= '0;
                        r_state <= BUSY;
                    end
                end
                BUSY: begin
                    if (m_ack_i || m_err_i) begin
                        r_m_cyc   <= 1'b0;
                        r_state   <= DONE;
                        r_err_cnt <= m_err_i ? sat_inc(r_err_cnt) : r_err_cnt;
                        if (r_grant == GRANT_B) begin
                            r_b_dat <= m_dat_i;
                            r_b_ack <= ~m_err_i;
                            r_b_err <= m_err_i;
                        end else begin
                            r_a_dat <= m_dat_i;
                            r_a_ack <= ~m_err_i;
                            r_a_err <= m_err_i;
                        end
                    end else if (r_timer == TMO) begin
                        r_m_cyc   <= 1'b0;
                        r_state   <= DONE;
                        r_err_cnt <= sat_inc(r_err_cnt);
                        r_a_err   <= (r_grant == GRANT_A);
                        r_b_err   <= (r_grant == GRANT_B);
                    end else begin
                        r_timer <= r_timer + 8'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign a_ack_o     = r_a_ack;
    assign a_err_o     = r_a_err;
    assign a_rty_o     = 1'b0;
    assign a_dat_o     = r_a_dat;
    assign b_ack_o     = r_b_ack;
    assign b_err_o     = r_b_err;
    assign b_rty_o     = 1'b0;
    assign b_dat_o     = r_b_dat;
    assign m_cyc_o     = r_m_cyc;
    assign m_stb_o     = r_m_cyc;
    assign m_we_o      = r_m_we;
    assign m_adr_o     = r_m_adr;
    assign m_dat_o     = r_m_dat;
    assign m_sel_o     = 4'hF;
    assign err_count_o = r_err_cnt;

endmodule

// File: tb/tb_l1_wb_arbiter.sv
// tb_l1_wb_arbiter: vector table plus scoreboard bench for the L1 Wishbone arbiter
module tb_l1_wb_arbiter;

    localparam int M_ACK  = 0;
    localparam int M_ERR  = 1;
    localparam int M_AE   = 2;
    localparam int M_NONE = 3;

    typedef struct {
        logic        host;
        logic        we;
        logic [14:0] adr;
        logic [31:0] wdat;
        int          lat;
        int          mode;
        logic [31:0] rdat;
    } vec_t;

    typedef struct {
        logic [3:0]  term;
        logic [31:0] dat;
    } exp_t;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i = 1'b1;
    logic        a_cyc_i = 0, a_stb_i = 0, a_we_i = 0;
    logic [14:0] a_adr_i = '0;
    logic [31:0] a_dat_i = '0;
    logic        b_cyc_i = 0, b_stb_i = 0, b_we_i = 0;
    logic [14:0] b_adr_i = '0;
    logic [31:0] b_dat_i = '0;
    logic        m_ack_i = 0, m_err_i = 0, m_rty_i = 0;
    logic [31:0] m_dat_i = '0;
    logic        a_ack_o, a_err_o, a_rty_o, b_ack_o, b_err_o, b_rty_o;
    logic [31:0] a_dat_o, b_dat_o, m_dat_o;
    logic        m_cyc_o, m_stb_o, m_we_o;
    logic [14:0] m_adr_o;
    logic [3:0]  m_sel_o;
    logic [7:0]  err_count_o;

    int          n_checks = 0;
    int          n_fail   = 0;
    exp_t        sb[$];
    logic [31:0] model_dat [2] = '{32'h0, 32'h0};
    int          model_cnt = 0;
    vec_t        vecs [6];

    l1_wb_arbiter #(.ADR_BITS(15), .DAT_BITS(32), .TIMEOUT(255)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
        .a_cyc_i(a_cyc_i), .a_stb_i(a_stb_i), .a_we_i(a_we_i), .a_adr_i(a_adr_i),
        .a_dat_i(a_dat_i), .a_sel_i(4'h3), .a_ack_o(a_ack_o), .a_err_o(a_err_o),
        .a_rty_o(a_rty_o), .a_dat_o(a_dat_o),
        .b_cyc_i(b_cyc_i), .b_stb_i(b_stb_i), .b_we_i(b_we_i), .b_adr_i(b_adr_i),
        .b_dat_i(b_dat_i), .b_sel_i(4'h1), .b_ack_o(b_ack_o), .b_err_o(b_err_o),
        .b_rty_o(b_rty_o), .b_dat_o(b_dat_o),
        .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_we_o(m_we_o), .m_adr_o(m_adr_o),
        .m_dat_o(m_dat_o), .m_sel_o(m_sel_o), .m_ack_i(m_ack_i), .m_err_i(m_err_i),
        .m_rty_i(m_rty_i), .m_dat_i(m_dat_i), .err_count_o(err_count_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    task automatic check(input string name, input logic [159:0] got, input logic [159:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [53:0] mstate();
        return {m_cyc_o, m_stb_o, m_we_o, m_adr_o, m_dat_o, m_sel_o};
    endfunction

    function automatic logic [53:0] gvec(input logic we, input logic [14:0] adr, input logic [31:0] dat);
        return {1'b1, 1'b1, we, adr, dat, 4'hF};
    endfunction

    function automatic logic [159:0] all_outs();
        return {a_ack_o, a_err_o, a_rty_o, a_dat_o, b_ack_o, b_err_o, b_rty_o, b_dat_o,
                m_cyc_o, m_stb_o, m_we_o, m_adr_o, m_dat_o, m_sel_o, err_count_o};
    endfunction

    task automatic set_host(input logic host, input logic on, input logic we,
                            input logic [14:0] adr, input logic [31:0] dat);
        if (host) begin
            b_cyc_i = on; b_stb_i = on; b_we_i = we; b_adr_i = adr; b_dat_i = dat;
        end else begin
            a_cyc_i = on; a_stb_i = on; a_we_i = we; a_adr_i = adr; a_dat_i = dat;
        end
    endtask

    // model of what the winner should see when its transaction terminates
    task automatic expect_term(input logic host, input int mode, input logic [31:0] rdat);
        exp_t e;
        if (mode != M_NONE) model_dat[host] = rdat;
        if (mode != M_ACK) model_cnt = (model_cnt >= 255) ? 255 : model_cnt + 1;
        e.term = host ? ((mode == M_ACK) ? 4'b0010 : 4'b0001)
                      : ((mode == M_ACK) ? 4'b1000 : 4'b0100);
        e.dat = model_dat[host];
        sb.push_back(e);
    endtask

    task automatic await_grant(input int edges, input logic [53:0] gv);
        for (int i = 0; i < edges; i++) begin
            @(posedge wb_clk_i); #1;
            if (i < edges - 1) check("idle_gap_cyc", m_cyc_o, 0);
        end
        check("grant", mstate(), gv);
    endtask

    task automatic respond(input int lat, input int mode, input logic [31:0] rdat, input logic [53:0] gv);
        for (int i = 1; i < lat; i++) begin
            @(posedge wb_clk_i); #1;
            check("busy_hold", mstate(), gv);
        end
        if (mode != M_NONE) begin
            m_dat_i = rdat;
            m_ack_i = (mode != M_ERR);
            m_err_i = (mode != M_ACK);
        end
        @(posedge wb_clk_i); #1;
        m_ack_i = 0;
        m_err_i = 0;
        check("term_cyc_drop", m_cyc_o, 0);
        check("err_count", err_count_o, model_cnt);
    endtask

    always @(negedge wb_clk_i) begin
        if (!wb_rst_i && ({a_ack_o, a_err_o, b_ack_o, b_err_o} != 4'b0)) begin
            if (sb.size() == 0) begin
                check("unexpected_term", {a_ack_o, a_err_o, b_ack_o, b_err_o}, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("term_pattern", {a_ack_o, a_err_o, b_ack_o, b_err_o}, e.term);
                check("host_dat", (e.term[1] | e.term[0]) ? b_dat_o : a_dat_o, e.dat);
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [53:0] gv;
        logic        h;
        vecs[0] = '{1'b0, 1'b0, 15'h2004, 32'h0,        4, M_ACK, 32'hDEADBEEF};
        vecs[1] = '{1'b1, 1'b1, 15'h6010, 32'h55,       1, M_ACK, 32'h0};
        vecs[2] = '{1'b0, 1'b1, 15'h0123, 32'hA5A5A5A5, 2, M_ERR, 32'h11111111};
        vecs[3] = '{1'b1, 1'b0, 15'h7FFF, 32'h0,        3, M_ACK, 32'hCAFEF00D};
        vecs[4] = '{1'b0, 1'b0, 15'h0000, 32'h0,        1, M_AE,  32'h12345678};
        vecs[5] = '{1'b1, 1'b0, 15'h4ABC, 32'h0,        5, M_ERR, 32'h87654321};

        repeat (3) @(posedge wb_clk_i);
        #1 check("reset_outputs", all_outs(), 160'hF00);
        @(negedge wb_clk_i) wb_rst_i = 0;
        @(posedge wb_clk_i); #1;

        // tie from reset with both hosts holding: A,B,A,B back-to-back
        set_host(0, 1, 0, 15'h2004, 32'h0BAD0000);
        set_host(1, 1, 1, 15'h6010, 32'h55);
        for (int i = 0; i < 4; i++) begin
            h  = i[0];
            gv = h ? gvec(1, 15'h6010, 32'h55) : gvec(0, 15'h2004, 32'h0BAD0000);
            expect_term(h, M_ACK, 32'hA0000000 + i);
            await_grant((i == 0) ? 1 : 2, gv);
            respond(1, M_ACK, 32'hA0000000 + i, gv);
        end
        set_host(0, 0, 0, 0, 0);
        set_host(1, 0, 0, 0, 0);
        @(posedge wb_clk_i); #1;

        // timeout, then a stale ack in IDLE
        gv = gvec(0, 15'h2100, 32'h0);
        set_host(0, 1, 0, 15'h2100, 32'h0);
        expect_term(0, M_NONE, 32'h0);
        await_grant(1, gv);
        respond(256, M_NONE, 32'h0, gv);
        check("timeout_count", err_count_o, 1);
        set_host(0, 0, 0, 0, 0);
        @(posedge wb_clk_i); #1;
        m_dat_i = 32'hBADBAD00;
        m_ack_i = 1;
        @(posedge wb_clk_i); #1;
        m_ack_i = 0;
        check("stale_ack_cyc", m_cyc_o, 0);
        check("stale_ack_count", err_count_o, 1);

        // ack on the same edge the timer reaches TIMEOUT
        gv = gvec(0, 15'h3000, 32'h0);
        set_host(1, 1, 0, 15'h3000, 32'h0);
        expect_term(1, M_ACK, 32'h600DF00D);
        await_grant(1, gv);
        respond(256, M_ACK, 32'h600DF00D, gv);
        set_host(1, 0, 0, 0, 0);
        @(posedge wb_clk_i); #1;

        foreach (vecs[n]) begin
            gv = gvec(vecs[n].we, vecs[n].adr, vecs[n].wdat);
            set_host(vecs[n].host, 1, vecs[n].we, vecs[n].adr, vecs[n].wdat);
            expect_term(vecs[n].host, vecs[n].mode, vecs[n].rdat);
            await_grant(1, gv);
            respond(vecs[n].lat, vecs[n].mode, vecs[n].rdat, gv);
            set_host(vecs[n].host, 0, 0, 0, 0);
            @(posedge wb_clk_i); #1;
        end

        // error-count saturation with A holding its request back-to-back
        gv = gvec(0, 15'h0040, 32'h0);
        set_host(0, 1, 0, 15'h0040, 32'h0);
        for (int i = 0; i < 260; i++) begin
            expect_term(0, M_ERR, 32'(i));
            await_grant((i == 0) ? 1 : 2, gv);
            respond(1, M_ERR, 32'(i), gv);
        end
        set_host(0, 0, 0, 0, 0);
        @(posedge wb_clk_i); #1;
        check("err_saturated", err_count_o, 255);

        // asynchronous reset in the middle of BUSY
        gv = gvec(0, 15'h1111, 32'h0);
        set_host(0, 1, 0, 15'h1111, 32'h0);
        await_grant(1, gv);
        @(posedge wb_clk_i); #3;
        wb_rst_i = 1;
        #1 check("async_reset_outputs", all_outs(), 160'hF00);
        sb.delete();
        model_dat = '{32'h0, 32'h0};
        model_cnt = 0;
        set_host(0, 0, 0, 0, 0);
        @(negedge wb_clk_i) wb_rst_i = 0;
        @(posedge wb_clk_i); #1;
        set_host(0, 1, 0, 15'h2004, 32'h0);
        set_host(1, 1, 1, 15'h6010, 32'h55);
        expect_term(0, M_ACK, 32'h0F0F0F0F);
        await_grant(1, gvec(0, 15'h2004, 32'h0));
        respond(2, M_ACK, 32'h0F0F0F0F, gvec(0, 15'h2004, 32'h0));
        set_host(0, 0, 0, 0, 0);
        expect_term(1, M_ACK, 32'h00000077);
        await_grant(2, gvec(1, 15'h6010, 32'h55));
        respond(1, M_ACK, 32'h00000077, gvec(1, 15'h6010, 32'h55));
        set_host(1, 0, 0, 0, 0);
        repeat (2) @(posedge wb_clk_i);
        #1 check("scoreboard_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
